// File: rtl/detector_jogada_pkg.sv
// Shared types and widths for the detector_jogada button-conditioning block.
package detector_jogada_pkg;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned ST_W  = 3;
    localparam int unsigned BTN_W = 4;

    typedef enum logic [ST_W-1:0] {
        OCIOSO       = 3'd0,
        FILTRA_PRESS = 3'd1,
        EMITE        = 3'd2,
        ESPERA_SOLTA = 3'd3,
        FILTRA_SOLTA = 3'd4
    } estado_t;

    // True when exactly one button is set in the pattern.
    function automatic logic is_one_hot(input logic [BTN_W-1:0] v);
        return (v != '0) && ((v & (v - BTN_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/detector_jogada_if.sv
// Play-detection bus between the button conditioner and the game datapath.
interface detector_jogada_if;
    import detector_jogada_pkg::*;

    logic               enable;
    logic [BTN_W-1:0]   botoes;
    logic [BTN_W-1:0]   jogada;
    logic               jogada_valida;
    logic               jogada_invalida;
    logic [ST_W-1:0]    db_estado;

    modport master (
        output enable, botoes,
        input  jogada, jogada_valida, jogada_invalida, db_estado
    );

    modport slave (
        input  enable, botoes,
        output jogada, jogada_valida, jogada_invalida, db_estado
    );
endinterface

// File: rtl/detector_jogada_sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous inputs; reused for other raw buttons.
module sincronizador_2ff #(
    parameter int unsigned W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Metastability filter: d -> meta -> q.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/detector_jogada.sv
// Synchronises, debounces and converts button presses into single-cycle plays.
// Optional build macro DETECTOR_JOGADA_MULTI_REJECT_EN: multi-button patterns
// raise jogada_invalida instead of jogada_valida.
module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    detector_jogada_if.slave  bus
);

    localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEB_CYCLES);
    localparam bit               DEB_UM = (DEB_CYCLES <= 1);

    logic [BTN_W-1:0] bs;
    estado_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [BTN_W-1:0] amostra_q, amostra_d;
    logic [BTN_W-1:0] jogada_q, jogada_d;
    logic             valida_q, valida_d;
    logic             invalida_q, invalida_d;

    sincronizador_2ff #(.W(BTN_W)) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (bus.botoes),
        .q     (bs)
    );

    // Saturating increment so a long hold never wraps the counter.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // State, counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= OCIOSO;
            cnt_q      <= '0;
            amostra_q  <= '0;
            jogada_q   <= '0;
            valida_q   <= 1'b0;
            invalida_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            amostra_q  <= amostra_d;
            jogada_q   <= jogada_d;
            valida_q   <= valida_d;
            invalida_q <= invalida_d;
        end
    end

    // Next-state logic; outputs are decoded from entry into EMITE so the
    // pulse and the code appear together for exactly one cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        amostra_d  = amostra_q;
        jogada_d   = jogada_q;
        valida_d   = 1'b0;
        invalida_d = 1'b0;

        case (state_q)
            OCIOSO: begin
                if (bs != '0) begin
                    if (bus.enable) begin
                        amostra_d = bs;
                        cnt_d     = CNT_W'(1);
                        state_d   = DEB_UM ? EMITE : FILTRA_PRESS;
                    end else begin
                        state_d = ESPERA_SOLTA;
                    end
                end
            end
            FILTRA_PRESS: begin
                if (!bus.enable) begin
                    state_d = ESPERA_SOLTA;
                end else if (bs == '0) begin
                    state_d = OCIOSO;
                end else if (bs == amostra_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= DEB_C) begin
                        state_d = EMITE;
                    end
                end else begin
                    amostra_d = bs;
                    cnt_d     = CNT_W'(1);
                end
            end
            EMITE: begin
                state_d = ESPERA_SOLTA;
            end
            ESPERA_SOLTA: begin
                if (bs == '0) begin
                    cnt_d   = CNT_W'(1);
                    state_d = DEB_UM ? OCIOSO : FILTRA_SOLTA;
                end
            end
            FILTRA_SOLTA: begin
                if (bs != '0) begin
                    state_d = ESPERA_SOLTA;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= DEB_C) begin
                        state_d = OCIOSO;
                    end
                end
            end
            default: begin
                state_d = OCIOSO;
            end
        endcase

        if (state_d == EMITE) begin
            jogada_d = amostra_d;
`ifdef DETECTOR_JOGADA_MULTI_REJECT_EN
            valida_d   = is_one_hot(amostra_d);
            invalida_d = !is_one_hot(amostra_d);
`else
            valida_d   = 1'b1;
`endif
        end
    end

    assign bus.jogada          = jogada_q;
    assign bus.jogada_valida   = valida_q;
    assign bus.jogada_invalida = invalida_q;
    assign bus.db_estado       = state_q;

endmodule
